mips_multicycle_control: RTL and testbench

Moore-style main control FSM for the multicycle variant of the MIPS processor. It shares one unified instruction/data memory port across fetch and load/store phases. It sequences PC, IR, register file and ALU enables per instruction class, and waits on a memory-ready handshake. It sits beside the existing ALUControl and replaces the single-cycle Control unit in the multicycle top level.

---
 rtl/mips_multicycle_control_if.sv | 52 +++++
 rtl/mips_multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The datapath supplies the decoded instruction fields, the ALU zero flag and
// the memory-ready handshake. The controller returns every enable and mux
// select, plus debug and status outputs.
//
// Signals:
//   opcode/funct   IR[31:26] / IR[5:0]     (datapath -> control)
//   zero           ALU zero flag           (datapath -> control)
//   memReady       memory completes access (datapath -> control)
//   pcWrite .. pcSource                    datapath enables and selects
//   state          current FSM state, for debug
//   illegalOp      sticky unsupported-opcode flag
//   instrCount     retired-instruction counter
interface mips_multicycle_control_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [5:0]             opcode;
    logic [5:0]             funct;
    logic                   zero;
    logic                   memReady;
    logic                   pcWrite;
    logic                   iorD;
    logic                   memRead;
    logic                   memWrite;
    logic                   irWrite;
    logic                   regDst;
    logic                   memtoReg;
    logic                   regWrite;
    logic                   aluSrcA;
    logic [1:0]             aluSrcB;
    logic [2:0]             aluOp;
    logic [1:0]             pcSource;
    logic [3:0]             state;
    logic                   illegalOp;
    logic [COUNT_WIDTH-1:0] instrCount;

    // Controller side
    modport master (
        input  opcode, funct, zero, memReady,
        output pcWrite, iorD, memRead, memWrite, irWrite, regDst, memtoReg,
               regWrite, aluSrcA, aluSrcB, aluOp, pcSource, state, illegalOp,
               instrCount
    );

    // Datapath side
    modport slave (
        output opcode, funct, zero, memReady,
        input  pcWrite, iorD, memRead, memWrite, irWrite, regDst, memtoReg,
               regWrite, aluSrcA, aluSrcB, aluOp, pcSource, state, illegalOp,
               instrCount
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore-style main control FSM for the multicycle MIPS processor.
// One unified memory port is shared between instruction fetch and load/store.
// The FSM waits on memReady in FETCH, MEMRD and MEMWR.
//
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    mips_multicycle_control_if.master (see interface header)
module mips_multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    mips_multicycle_control_if.master    bus
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] REXEC  = 4'd6;
    localparam logic [3:0] RWB    = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] JUMP   = 4'd9;
    localparam logic [3:0] IEXEC  = 4'd10;
    localparam logic [3:0] IWB    = 4'd11;
    localparam logic [3:0] JR     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    logic [3:0]             state_q, state_d;
    logic                   illegalOp_q, illegalOp_d;
    logic [COUNT_WIDTH-1:0] instrCount_q;
    logic                   retire;

    logic pcWriteRaw, irWriteRaw, regWriteRaw, memWriteRaw;

    // Next-state logic. retire marks every transition back into FETCH that
    // completes an instruction, so illegal opcodes never bump the counter.
    always_comb begin
        state_d     = state_q;
        illegalOp_d = illegalOp_q;
        retire      = 1'b0;
        case (state_q)
            FETCH:  if (bus.memReady) state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                         state_d = (bus.funct == FUNCT_JR) ? JR : REXEC;
                    OP_LW, OP_SW:                     state_d = MEMADR;
                    OP_BEQ, OP_BNE:                   state_d = BRANCH;
                    OP_J:                             state_d = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = IEXEC;
                    default: begin
                        state_d     = FETCH;
                        illegalOp_d = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (bus.memReady) state_d = MEMWB;
            MEMWR: begin
                if (bus.memReady) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            REXEC:  state_d = RWB;
            IEXEC:  state_d = IWB;
            MEMWB, RWB, IWB, BRANCH, JUMP, JR: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            // Codes 13..15 are unreachable; fall back to a clean fetch
            default: state_d = FETCH;
        endcase
    end

    // State, sticky illegal flag and the wrapping retire counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= FETCH;
            illegalOp_q  <= 1'b0;
            instrCount_q <= '0;
        end else begin
            state_q     <= state_d;
            illegalOp_q <= illegalOp_d;
            if (retire) instrCount_q <= instrCount_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Output decode from state only, except PCWrite/IRWrite which also
    // qualify on memReady (fetch) or the branch condition.
    always_comb begin
        pcWriteRaw   = 1'b0;
        irWriteRaw   = 1'b0;
        regWriteRaw  = 1'b0;
        memWriteRaw  = 1'b0;
        bus.iorD     = 1'b0;
        bus.memRead  = 1'b0;
        bus.regDst   = 1'b0;
        bus.memtoReg = 1'b0;
        bus.aluSrcA  = 1'b0;
        bus.aluSrcB  = 2'b00;
        bus.aluOp    = 3'b000;
        bus.pcSource = 2'b00;
        case (state_q)
            FETCH: begin
                bus.memRead = 1'b1;
                bus.aluSrcB = 2'b01;
                pcWriteRaw  = bus.memReady;
                irWriteRaw  = bus.memReady;
            end
            DECODE: bus.aluSrcB = 2'b11;
            MEMADR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
            end
            MEMRD: begin
                bus.iorD    = 1'b1;
                bus.memRead = 1'b1;
            end
            MEMWB: begin
                bus.memtoReg = 1'b1;
                regWriteRaw  = 1'b1;
            end
            MEMWR: begin
                bus.iorD    = 1'b1;
                memWriteRaw = 1'b1;
            end
            REXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = 3'b010;
            end
            RWB: begin
                bus.regDst  = 1'b1;
                regWriteRaw = 1'b1;
            end
            BRANCH: begin
                bus.aluSrcA  = 1'b1;
                bus.aluOp    = 3'b001;
                bus.pcSource = 2'b01;
                pcWriteRaw   = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                               ((bus.opcode == OP_BNE) && !bus.zero);
            end
            JUMP: begin
                bus.pcSource = 2'b10;
                pcWriteRaw   = 1'b1;
            end
            IEXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                case (bus.opcode)
                    OP_ANDI: bus.aluOp = 3'b100;
                    OP_ORI:  bus.aluOp = 3'b011;
                    OP_LUI:  bus.aluOp = 3'b101;
                    default: bus.aluOp = 3'b000;
                endcase
            end
            IWB: regWriteRaw = 1'b1;
            JR: begin
                bus.pcSource = 2'b11;
                pcWriteRaw   = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural write enables are killed combinationally by reset so no
    // partial write can complete once reset is asserted.
    assign bus.pcWrite    = pcWriteRaw  & ~rst_i;
    assign bus.irWrite    = irWriteRaw  & ~rst_i;
    assign bus.regWrite   = regWriteRaw & ~rst_i;
    assign bus.memWrite   = memWriteRaw & ~rst_i;
    assign bus.state      = state_q;
    assign bus.illegalOp  = illegalOp_q;
    assign bus.instrCount = instrCount_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Testbench for mips_multicycle_control. Directed instruction sequences are
// driven one cycle at a time; each cycle pushes the expected state, control
// word, counter and illegal flag into a scoreboard queue that an independent
// monitor drains on the falling edge.
module tb_mips_multicycle_control;

    typedef struct {
        logic [3:0]  state;
        logic [15:0] ctrl;
        logic [31:0] count;
        logic        illegal;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cycleIdx;
    exp_t sb[$];

    mips_multicycle_control_if #(.COUNT_WIDTH(32)) bus();

    mips_multicycle_control #(.COUNT_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word from the documented per-state table:
    // {pcWrite,iorD,memRead,memWrite,irWrite,regDst,memtoReg,regWrite,
    //  aluSrcA,aluSrcB[1:0],aluOp[2:0],pcSource[1:0]}
    function automatic logic [15:0] expCtrl(input logic [3:0] st, input logic [5:0] op,
                                            input logic z, input logic rdy, input logic r);
        logic pw, iod, mr, mw, iw, rd, m2r, rw, sa;
        logic [1:0] sb2, ps;
        logic [2:0] ao;
        {pw, iod, mr, mw, iw, rd, m2r, rw, sa} = '0;
        sb2 = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            4'd0:  begin mr = 1; sb2 = 2'b01; pw = rdy; iw = rdy; end
            4'd1:  sb2 = 2'b11;
            4'd2:  begin sa = 1; sb2 = 2'b10; end
            4'd3:  begin iod = 1; mr = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iod = 1; mw = 1; end
            4'd6:  begin sa = 1; ao = 3'b010; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; ao = 3'b001; ps = 2'b01;
                         pw = (op == 6'h04 && z) || (op == 6'h05 && !z); end
            4'd9:  begin ps = 2'b10; pw = 1; end
            4'd10: begin sa = 1; sb2 = 2'b10;
                         ao = (op == 6'h0C) ? 3'b100 : (op == 6'h0D) ? 3'b011 :
                              (op == 6'h0F) ? 3'b101 : 3'b000; end
            4'd11: rw = 1;
            4'd12: begin ps = 2'b11; pw = 1; end
            default: ;
        endcase
        if (r) begin pw = 0; iw = 0; rw = 0; mw = 0; end
        return {pw, iod, mr, mw, iw, rd, m2r, rw, sa, sb2, ao, ps};
    endfunction

    // Drive one cycle of inputs shortly after the rising edge and record
    // what the DUT should present for the rest of that cycle.
    task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy, input logic [3:0] st,
                                 input int cnt, input logic ill);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        bus.opcode   = op;
        bus.funct    = fn;
        bus.zero     = z;
        bus.memReady = rdy;
        e.state   = st;
        e.ctrl    = expCtrl(st, op, z, rdy, r);
        e.count   = cnt;
        e.illegal = ill;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycleIdx, got, exp);
        end
    endtask

    // Monitor: the DUT presents a full control word every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("state", {28'd0, bus.state}, {28'd0, e.state});
                checkOutput("ctrl", {16'd0, bus.pcWrite, bus.iorD, bus.memRead, bus.memWrite,
                                     bus.irWrite, bus.regDst, bus.memtoReg, bus.regWrite,
                                     bus.aluSrcA, bus.aluSrcB, bus.aluOp, bus.pcSource},
                            {16'd0, e.ctrl});
                checkOutput("instrCount", bus.instrCount, e.count);
                checkOutput("illegalOp", {31'd0, bus.illegalOp}, {31'd0, e.illegal});
                cycleIdx++;
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        cycleIdx     = 0;
        rst          = 1'b1;
        bus.opcode   = 6'h00;
        bus.funct    = 6'h00;
        bus.zero     = 1'b0;
        bus.memReady = 1'b0;

        // Reset: fetch enables stay low even with memReady high
        applyStimulus(1, 6'h00, 6'h20, 0, 1, 4'd0, 0, 0);

        // R-type add: 0,1,6,7
        applyStimulus(0, 6'h00, 6'h20, 0, 1, 4'd0, 0, 0);
        applyStimulus(0, 6'h00, 6'h20, 0, 1, 4'd1, 0, 0);
        applyStimulus(0, 6'h00, 6'h20, 0, 1, 4'd6, 0, 0);
        applyStimulus(0, 6'h00, 6'h20, 0, 1, 4'd7, 0, 0);

        // lw with two wait cycles in MEMRD
        applyStimulus(0, 6'h23, 6'h00, 0, 1, 4'd0, 1, 0);
        applyStimulus(0, 6'h23, 6'h00, 0, 1, 4'd1, 1, 0);
        applyStimulus(0, 6'h23, 6'h00, 0, 1, 4'd2, 1, 0);
        applyStimulus(0, 6'h23, 6'h00, 0, 0, 4'd3, 1, 0);
        applyStimulus(0, 6'h23, 6'h00, 0, 0, 4'd3, 1, 0);
        applyStimulus(0, 6'h23, 6'h00, 0, 1, 4'd3, 1, 0);
        applyStimulus(0, 6'h23, 6'h00, 0, 1, 4'd4, 1, 0);

        // beq taken (Zero=1)
        applyStimulus(0, 6'h04, 6'h00, 1, 1, 4'd0, 2, 0);
        applyStimulus(0, 6'h04, 6'h00, 1, 1, 4'd1, 2, 0);
        applyStimulus(0, 6'h04, 6'h00, 1, 1, 4'd8, 2, 0);

        // bne not taken (Zero=1)
        applyStimulus(0, 6'h05, 6'h00, 1, 1, 4'd0, 3, 0);
        applyStimulus(0, 6'h05, 6'h00, 1, 1, 4'd1, 3, 0);
        applyStimulus(0, 6'h05, 6'h00, 1, 1, 4'd8, 3, 0);

        // Illegal opcode: back to fetch, flag sticks, no retire
        applyStimulus(0, 6'h3F, 6'h00, 0, 1, 4'd0, 4, 0);
        applyStimulus(0, 6'h3F, 6'h00, 0, 1, 4'd1, 4, 0);

        // ori
        applyStimulus(0, 6'h0D, 6'h00, 0, 1, 4'd0, 4, 1);
        applyStimulus(0, 6'h0D, 6'h00, 0, 1, 4'd1, 4, 1);
        applyStimulus(0, 6'h0D, 6'h00, 0, 1, 4'd10, 4, 1);
        applyStimulus(0, 6'h0D, 6'h00, 0, 1, 4'd11, 4, 1);

        // jr
        applyStimulus(0, 6'h00, 6'h08, 0, 1, 4'd0, 5, 1);
        applyStimulus(0, 6'h00, 6'h08, 0, 1, 4'd1, 5, 1);
        applyStimulus(0, 6'h00, 6'h08, 0, 1, 4'd12, 5, 1);

        // j
        applyStimulus(0, 6'h02, 6'h00, 0, 1, 4'd0, 6, 1);
        applyStimulus(0, 6'h02, 6'h00, 0, 1, 4'd1, 6, 1);
        applyStimulus(0, 6'h02, 6'h00, 0, 1, 4'd9, 6, 1);

        // sw with one fetch wait, store completes immediately
        applyStimulus(0, 6'h2B, 6'h00, 0, 0, 4'd0, 7, 1);
        applyStimulus(0, 6'h2B, 6'h00, 0, 1, 4'd0, 7, 1);
        applyStimulus(0, 6'h2B, 6'h00, 0, 1, 4'd1, 7, 1);
        applyStimulus(0, 6'h2B, 6'h00, 0, 1, 4'd2, 7, 1);
        applyStimulus(0, 6'h2B, 6'h00, 0, 1, 4'd5, 7, 1);

        // sw stalled in MEMWR, then reset asserted mid-cycle
        applyStimulus(0, 6'h2B, 6'h00, 0, 1, 4'd0, 8, 1);
        applyStimulus(0, 6'h2B, 6'h00, 0, 1, 4'd1, 8, 1);
        applyStimulus(0, 6'h2B, 6'h00, 0, 0, 4'd2, 8, 1);
        applyStimulus(0, 6'h2B, 6'h00, 0, 0, 4'd5, 8, 1);
        applyStimulus(1, 6'h2B, 6'h00, 0, 0, 4'd0, 0, 0);
        applyStimulus(1, 6'h2B, 6'h00, 0, 1, 4'd0, 0, 0);

        // andi after reset
        applyStimulus(0, 6'h0C, 6'h00, 0, 1, 4'd0, 0, 0);
        applyStimulus(0, 6'h0C, 6'h00, 0, 1, 4'd1, 0, 0);
        applyStimulus(0, 6'h0C, 6'h00, 0, 1, 4'd10, 0, 0);
        applyStimulus(0, 6'h0C, 6'h00, 0, 1, 4'd11, 0, 0);

        // lui
        applyStimulus(0, 6'h0F, 6'h00, 0, 1, 4'd0, 1, 0);
        applyStimulus(0, 6'h0F, 6'h00, 0, 1, 4'd1, 1, 0);
        applyStimulus(0, 6'h0F, 6'h00, 0, 1, 4'd10, 1, 0);
        applyStimulus(0, 6'h0F, 6'h00, 0, 1, 4'd11, 1, 0);
        applyStimulus(0, 6'h0F, 6'h00, 0, 0, 4'd0, 2, 0);

        // Let the monitor drain the last entry
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
